// File: rtl/traffic_pkg.sv
// Lamp codes, FSM state encoding and the duration-load helper shared by
// the traffic phase controller and its bench.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    // Counter preload for a state lasting dur ticks; a zero duration still lasts one tick.
    function automatic logic [7:0] load_cnt(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd0 : dur - 8'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick strobe every DIV cycles.
module tick_prescaler #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Fixed-cycle traffic phase controller with night flashing mode.
// Define TRAFFIC_PED_REQ_EN to serve the pedestrian phase only on request.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_GROUPS = 14,
    parameter int N_PHASES = 3,
    parameter logic [N_PHASES*N_GROUPS-1:0] PHASE_MASK =
        {14'b11_0000_0000_0000, 14'b00_1111_1100_0000, 14'b00_0000_0011_1111},
    parameter logic [N_PHASES*8-1:0] GREEN_T = {8'd10, 8'd30, 8'd30},
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int TICK_DIV  = 50_000_000,
    parameter int PED_PHASE = N_PHASES - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          night_mode,
    input  logic                          ped_req,
    output logic [3*N_GROUPS-1:0]         lights,
    output logic [$clog2(N_PHASES)-1:0]   phase,
    output logic [1:0]                    state,
    output logic [7:0]                    remaining,
    output logic                          ped_wait,
    output logic                          sec_tick
);

    localparam int PW = $clog2(N_PHASES);
    localparam logic [PW-1:0] LAST_PH = PW'(N_PHASES - 1);
    localparam logic [PW-1:0] PED_PH  = PW'(PED_PHASE);
    localparam logic [3*N_GROUPS-1:0] ALL_RED = {N_GROUPS{LAMP_RED}};
    localparam logic [3*N_GROUPS-1:0] ALL_YEL = {N_GROUPS{LAMP_YELLOW}};
    localparam logic [3*N_GROUPS-1:0] ALL_OFF = {N_GROUPS{LAMP_OFF}};

`ifdef TRAFFIC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d, next_ph;
    logic [7:0]            cnt_q, cnt_d;
    logic [3*N_GROUPS-1:0] lights_q, lights_d;
    logic                  flash_q, flash_d;
    logic                  ped_pending_q, ped_pending_d;
    logic                  tick;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic logic [3*N_GROUPS-1:0] paint(input logic [N_GROUPS-1:0] mask,
                                                    input logic [2:0] on_code);
        logic [3*N_GROUPS-1:0] l;
        l = '0;
        for (int g = 0; g < N_GROUPS; g++) l[3*g +: 3] = mask[g] ? on_code : LAMP_RED;
        return l;
    endfunction

    function automatic logic [N_GROUPS-1:0] mask_of(input logic [PW-1:0] p);
        return PHASE_MASK[int'(p)*N_GROUPS +: N_GROUPS];
    endfunction

    // Phase served after the current all-red; an unrequested pedestrian phase is skipped.
    always_comb begin
        next_ph = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
        if (PED_EN && next_ph == PED_PH && !ped_pending_q)
            next_ph = (PED_PH == LAST_PH) ? '0 : PED_PH + PW'(1);
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        lights_d      = lights_q;
        flash_d       = flash_q;
        ped_pending_d = ped_pending_q | (PED_EN & ped_req);
        if (tick) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                case (state_q)
                    S_GREEN: begin
                        state_d  = S_YELLOW;
                        cnt_d    = load_cnt(8'(YELLOW_T));
                        lights_d = paint(mask_of(phase_q), LAMP_YELLOW);
                    end
                    S_YELLOW: begin
                        state_d  = S_ALLRED;
                        cnt_d    = load_cnt(8'(ALLRED_T));
                        lights_d = ALL_RED;
                    end
                    S_ALLRED: begin
                        if (night_mode) begin
                            state_d  = S_FLASH;
                            cnt_d    = 8'd0;
                            flash_d  = 1'b0;
                            lights_d = ALL_YEL;
                        end else begin
                            state_d  = S_GREEN;
                            phase_d  = next_ph;
                            cnt_d    = load_cnt(GREEN_T[int'(next_ph)*8 +: 8]);
                            lights_d = paint(mask_of(next_ph), LAMP_GREEN);
                            if (next_ph == PED_PH) ped_pending_d = 1'b0;
                        end
                    end
                    S_FLASH: begin
                        if (!night_mode) begin
                            // Park on the last phase so phase 0 follows the clearance.
                            state_d  = S_ALLRED;
                            phase_d  = LAST_PH;
                            cnt_d    = load_cnt(8'(ALLRED_T));
                            flash_d  = 1'b0;
                            lights_d = ALL_RED;
                        end else begin
                            lights_d = flash_q ? ALL_YEL : ALL_OFF;
                            flash_d  = ~flash_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ALLRED;
            phase_q       <= LAST_PH;
            cnt_q         <= load_cnt(8'(ALLRED_T));
            lights_q      <= ALL_RED;
            flash_q       <= 1'b0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            lights_q      <= lights_d;
            flash_q       <= flash_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    assign lights    = lights_q;
    assign phase     = phase_q;
    assign state     = state_q;
    assign remaining = cnt_q;
    assign ped_wait  = ped_pending_q;
    assign sec_tick  = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: expected state-change events are
// queued up front and a monitor pops one per observed change.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    localparam logic [11:0] MASKS  = {4'b0000, 4'b1100, 4'b0011};
    localparam logic [23:0] GTS    = {8'd2, 8'd5, 8'd5};
    localparam logic [11:0] L_ALLR = 12'b100_100_100_100;
    localparam logic [11:0] L_G0   = 12'b100_100_001_001;
    localparam logic [11:0] L_Y0   = 12'b100_100_010_010;
    localparam logic [11:0] L_G1   = 12'b001_001_100_100;
    localparam logic [11:0] L_Y1   = 12'b010_010_100_100;
    localparam logic [11:0] L_FY   = 12'b010_010_010_010;
    localparam logic [11:0] L_FO   = 12'b000_000_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        night_mode = 1'b0;
    logic        ped_req = 1'b0;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic [1:0]  state;
    logic [7:0]  remaining;
    logic        ped_wait;
    logic        sec_tick;

    traffic_phase_ctrl #(
        .N_GROUPS(4), .N_PHASES(3), .PHASE_MASK(MASKS), .GREEN_T(GTS),
        .YELLOW_T(3), .ALLRED_T(1), .TICK_DIV(4), .PED_PHASE(2)
    ) dut (
        .clk(clk), .rst(rst), .night_mode(night_mode), .ped_req(ped_req),
        .lights(lights), .phase(phase), .state(state), .remaining(remaining),
        .ped_wait(ped_wait), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  ph;
        logic [11:0] li;
        logic [7:0]  rem;
        logic        pw;
        int          dwell;
    } exp_t;

    exp_t  sbq[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_evt = 0;
    int    tick_ref = 0;
    int    ev_idx = 0;
    logic  rst_d1 = 1'b1;
    logic  was_rst = 1'b0;
    logic  in_rst;
    logic  tick_first = 1'b1;
    logic [16:0] snap, snap_prev;

    task automatic push(input logic [1:0] st, input int ph, input logic [11:0] li,
                        input int rem, input logic pw, input int dwell);
        exp_t e;
        e.st = st; e.ph = 2'(ph); e.li = li; e.rem = 8'(rem); e.pw = pw; e.dwell = dwell;
        sbq.push_back(e);
    endtask

    task automatic check_event(input int dw);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got st=%0d ph=%0d lights=%b rem=%0d pw=%b dwell=%0d",
                     state, phase, lights, remaining, ped_wait, dw);
        end else begin
            e = sbq.pop_front();
            if (state !== e.st || phase !== e.ph || lights !== e.li || remaining !== e.rem ||
                ped_wait !== e.pw || (e.dwell >= 0 && dw != e.dwell)) begin
                failures++;
                $display("FAIL event%0d got st=%0d ph=%0d lights=%b rem=%0d pw=%b dwell=%0d need st=%0d ph=%0d lights=%b rem=%0d pw=%b dwell=%0d",
                         ev_idx, state, phase, lights, remaining, ped_wait, dw,
                         e.st, e.ph, e.li, e.rem, e.pw, e.dwell);
            end
        end
        ev_idx++;
    endtask

    // Monitor: inputs change just after posedge, so rst seen at the previous
    // negedge is what the last posedge sampled.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            in_rst = rst_d1;
            rst_d1 = rst;
            snap   = {state, phase, lights, ped_wait};
            if (in_rst) begin
                if (!was_rst) check_event(-1);
                last_evt = cyc;
                tick_ref = cyc;
                tick_first = 1'b1;
                checks++;
                if (sec_tick !== 1'b0) begin
                    failures++;
                    $display("FAIL tick_in_reset got=%b need=0", sec_tick);
                end
            end else begin
                if (snap !== snap_prev) begin
                    check_event(cyc - last_evt);
                    last_evt = cyc;
                end
                if (sec_tick === 1'b1) begin
                    checks++;
                    if ((cyc - tick_ref) != (tick_first ? 3 : 4)) begin
                        failures++;
                        $display("FAIL tick_period got=%0d need=%0d", cyc - tick_ref, tick_first ? 3 : 4);
                    end
                    tick_ref = cyc;
                    tick_first = 1'b0;
                end
            end
            snap_prev = snap;
            was_rst = in_rst;
        end
    end

    task automatic wait_entry(input logic [1:0] st, input int ph, input string nm);
        logic prev, cur;
        prev = (state == st) && (ph < 0 || int'(phase) == ph);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            cur = (state == st) && (ph < 0 || int'(phase) == ph);
            if (cur && !prev) return;
            prev = cur;
        end
        checks++;
        failures++;
        $display("FAIL timeout_%s got st=%0d ph=%0d need st=%0d ph=%0d", nm, state, phase, st, ph);
    endtask

    task automatic push_yellow_allred_0;
        push(S_YELLOW, 0, L_Y0, 2, 0, 20);
        push(S_ALLRED, 0, L_ALLR, 0, 0, 12);
    endtask

    initial begin : stim
        // reset state
        push(S_ALLRED, 2, L_ALLR, 0, 0, -1);
        // free-running cycle
        push(S_GREEN, 0, L_G0, 4, 0, 4);
        push_yellow_allred_0();
        push(S_GREEN, 1, L_G1, 4, 0, 4);
        push(S_YELLOW, 1, L_Y1, 2, 0, 20);
        push(S_ALLRED, 1, L_ALLR, 0, 0, 12);
`ifndef TRAFFIC_PED_REQ_EN
        push(S_GREEN, 2, L_ALLR, 1, 0, 4);
        push(S_YELLOW, 2, L_ALLR, 2, 0, 8);
        push(S_ALLRED, 2, L_ALLR, 0, 0, 12);
`endif
        push(S_GREEN, 0, L_G0, 4, 0, 4);
        // pedestrian request during phase 1
        push_yellow_allred_0();
        push(S_GREEN, 1, L_G1, 4, 0, 4);
`ifdef TRAFFIC_PED_REQ_EN
        push(S_GREEN, 1, L_G1, 4, 1, 1);
        push(S_YELLOW, 1, L_Y1, 2, 1, 19);
        push(S_ALLRED, 1, L_ALLR, 0, 1, 12);
`else
        push(S_YELLOW, 1, L_Y1, 2, 0, 20);
        push(S_ALLRED, 1, L_ALLR, 0, 0, 12);
`endif
        push(S_GREEN, 2, L_ALLR, 1, 0, 4);
        push(S_YELLOW, 2, L_ALLR, 2, 0, 8);
        push(S_ALLRED, 2, L_ALLR, 0, 0, 12);
        push(S_GREEN, 0, L_G0, 4, 0, 4);
        // night mode requested in phase 1 green
        push_yellow_allred_0();
        push(S_GREEN, 1, L_G1, 4, 0, 4);
        push(S_YELLOW, 1, L_Y1, 2, 0, 20);
        push(S_ALLRED, 1, L_ALLR, 0, 0, 12);
        push(S_FLASH, 1, L_FY, 0, 0, 4);
        push(S_FLASH, 1, L_FO, 0, 0, 4);
        push(S_FLASH, 1, L_FY, 0, 0, 4);
        push(S_ALLRED, 2, L_ALLR, 0, 0, 4);
        push(S_GREEN, 0, L_G0, 4, 0, 4);
        // reset in yellow with counter at 1
        push(S_YELLOW, 0, L_Y0, 2, 0, 20);
        push(S_ALLRED, 2, L_ALLR, 0, 0, -1);
        push(S_GREEN, 0, L_G0, 4, 0, 4);
        push(S_YELLOW, 0, L_Y0, 2, 0, 20);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_entry(S_GREEN, 0, "first_green");
        wait_entry(S_GREEN, 0, "wrap_green");

        wait_entry(S_GREEN, 1, "ped_green1");
        ped_req = 1'b1;
        @(posedge clk); #1 ped_req = 1'b0;
        wait_entry(S_GREEN, 0, "ped_green0");

        wait_entry(S_GREEN, 1, "night_green1");
        night_mode = 1'b1;
        wait_entry(S_FLASH, -1, "flash");
        repeat (10) @(posedge clk);
        #1 night_mode = 1'b0;
        wait_entry(S_GREEN, 0, "day_green0");

        wait_entry(S_YELLOW, 0, "rst_yellow");
        for (int n = 0; n < 20 && remaining != 8'd1; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_entry(S_YELLOW, 0, "post_rst_yellow");
        repeat (3) @(posedge clk);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL leftover_events got=%0d need=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
